// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared types and constants for the 1:11 slot demux bank.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

  // Control states of the bank
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Slot geometry
  localparam int NUM_SLOTS    = 11;
  localparam int DEFAULT_SLOT = 9;
  localparam int LAST_SLOT    = 10;

  // Slot index type (a..k encoded as 0..10)
  typedef logic [3:0] slot_idx_t;

  localparam slot_idx_t LAST_SLOT_IDX = 4'd10;

  // True when an index names a real slot
  function automatic logic slot_in_range(input slot_idx_t idx);
    return (idx <= LAST_SLOT_IDX);
  endfunction

endpackage : demux_pkg
`default_nettype wire

// File: rtl/slot_decoder.sv
`default_nettype none
// ============================================================================
// Module      : slot_decoder
// Description : Combinational 4-to-11 one-hot slot decoder. Indices above the
//               last slot fall back to DEFAULT_SLOT and raise err, matching the
//               read-side mux default. All outputs are zero while en is low.
// Revision    : 1.0 - initial release
// ============================================================================
module slot_decoder
  import demux_pkg::*;
(
  input  logic                 en,
  input  slot_idx_t            sel,
  output logic [NUM_SLOTS-1:0] onehot,
  output logic                 err
);

  // Decode the index; out-of-range indices map onto the default slot
  always_comb begin
    onehot = '0;
    err    = 1'b0;
    if (en) begin
      if (slot_in_range(sel)) begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
          if (sel == slot_idx_t'(s)) begin
            onehot[s] = 1'b1;
          end
        end
      end else begin
        onehot[DEFAULT_SLOT] = 1'b1;
        err                  = 1'b1;
      end
    end
  end

endmodule : slot_decoder
`default_nettype wire

// File: rtl/demux_1_11_bank.sv
`default_nettype none
// ============================================================================
// Module      : demux_1_11_bank
// Description : 1:11 demultiplexer bank. Scatters valid/ready words into
//               eleven registered slots (a..k), either by explicit select
//               (addressed mode) or by an automatic 0..10 sweep (sweep mode).
//               Optional macro DEMUX_CLEAR_ON_START_EN: an accepted start
//               zeroes every slot on the same edge (a same-cycle write to
//               slot a still lands).
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1_11_bank
  import demux_pkg::*;
#(
  parameter int N = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [3:0]           select,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         data,
  output logic [N-1:0]         a,
  output logic [N-1:0]         b,
  output logic [N-1:0]         c,
  output logic [N-1:0]         d,
  output logic [N-1:0]         e,
  output logic [N-1:0]         f,
  output logic [N-1:0]         g,
  output logic [N-1:0]         h,
  output logic [N-1:0]         i,
  output logic [N-1:0]         j,
  output logic [N-1:0]         k,
  output logic [NUM_SLOTS-1:0] wr_strobe,
  output logic                 frame_done,
  output logic                 err_sel
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  slot_idx_t              r_ptr;
  slot_idx_t              w_ptr_nxt;
  logic [NUM_SLOTS-1:0]   r_wr_strobe;
  logic                   r_frame_done;
  logic                   r_err_sel;

  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_restart;
  logic                   w_frame_last;
  slot_idx_t              w_wr_idx;
  logic [NUM_SLOTS-1:0]   w_wr_en;
  logic                   w_dec_err;
  logic [NUM_SLOTS*N-1:0] w_slot_bus;

  // Ready only in addressed IDLE or SWEEP, and never while reset is applied
  assign w_in_ready = ~rst & (((r_state == IDLE) & ~mode) | (r_state == SWEEP));
  assign w_accept   = in_valid & w_in_ready;

  // A start seen in SWEEP restarts the frame from slot a
  assign w_restart  = start & (r_state == SWEEP);

  // The 11th sweep write (without a restart) closes the frame
  assign w_frame_last = (r_state == SWEEP) & ~start & w_accept & (r_ptr == LAST_SLOT_IDX);

  // Target slot: explicit select in IDLE, otherwise the sweep pointer
  assign w_wr_idx = (r_state == IDLE) ? select :
                    (w_restart ? slot_idx_t'(0) : r_ptr);

  // One decoder drives both the slot write enables and the strobe
  slot_decoder u_slot_decoder (
    .en     (w_accept),
    .sel    (w_wr_idx),
    .onehot (w_wr_en),
    .err    (w_dec_err)
  );

`ifdef DEMUX_CLEAR_ON_START_EN
  logic w_start_acc;

  // Starts that are honoured: IDLE in sweep mode, or a restart in SWEEP
  assign w_start_acc = start & (((r_state == IDLE) & mode) | (r_state == SWEEP));
`endif

  // Next-state and pointer logic
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (mode && start) begin
          w_state_nxt = SWEEP;
          w_ptr_nxt   = '0;
        end
      end
      SWEEP: begin
        if (start) begin
          w_ptr_nxt = w_accept ? slot_idx_t'(1) : slot_idx_t'(0);
        end else if (w_accept) begin
          if (r_ptr == LAST_SLOT_IDX) begin
            w_state_nxt = DONE;
            w_ptr_nxt   = '0;
          end else begin
            w_ptr_nxt = r_ptr + slot_idx_t'(1);
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // State, pointer and single-cycle status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_wr_strobe  <= '0;
      r_frame_done <= 1'b0;
      r_err_sel    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_wr_strobe  <= w_wr_en;
      r_frame_done <= w_frame_last;
      r_err_sel    <= w_dec_err;
    end
  end

  // Slot storage: one register per slot, packed onto a shared bus
  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    logic [N-1:0] r_val;

    // Write wins over the optional frame-start clear
    always_ff @(posedge clk) begin
      if (rst) begin
        r_val <= '0;
      end else if (w_wr_en[s]) begin
        r_val <= data;
      end
`ifdef DEMUX_CLEAR_ON_START_EN
      else if (w_start_acc) begin
        r_val <= '0;
      end
`endif
    end

    assign w_slot_bus[s*N +: N] = r_val;
  end

  assign a = w_slot_bus[0*N  +: N];
  assign b = w_slot_bus[1*N  +: N];
  assign c = w_slot_bus[2*N  +: N];
  assign d = w_slot_bus[3*N  +: N];
  assign e = w_slot_bus[4*N  +: N];
  assign f = w_slot_bus[5*N  +: N];
  assign g = w_slot_bus[6*N  +: N];
  assign h = w_slot_bus[7*N  +: N];
  assign i = w_slot_bus[8*N  +: N];
  assign j = w_slot_bus[9*N  +: N];
  assign k = w_slot_bus[10*N +: N];

  assign in_ready   = w_in_ready;
  assign wr_strobe  = r_wr_strobe;
  assign frame_done = r_frame_done;
  assign err_sel    = r_err_sel;

endmodule : demux_1_11_bank
`default_nettype wire

// File: tb/tb_demux_1_11_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1_11_bank
// Description : Scoreboard bench for demux_1_11_bank. The driver keeps a
//               behavioural model of the slot bank and queues the expected
//               strobe/done/err event per accepted beat; a monitor pops and
//               compares whenever the DUT presents an event.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1_11_bank;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mode;
  logic [3:0]   select;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] data;
  logic [N-1:0] a, b, c, d, e, f, g, h, i, j, k;
  logic [10:0]  wr_strobe;
  logic         frame_done;
  logic         err_sel;

  always #5 clk = ~clk;

  demux_1_11_bank #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .select     (select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data       (data),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .e          (e),
    .f          (f),
    .g          (g),
    .h          (h),
    .i          (i),
    .j          (j),
    .k          (k),
    .wr_strobe  (wr_strobe),
    .frame_done (frame_done),
    .err_sel    (err_sel)
  );

  typedef struct packed {
    logic [10:0] strobe;
    logic        done;
    logic        err;
  } ev_t;

  ev_t          q[$];
  logic [N-1:0] m_slots[11];
  bit           m_in_frame;
  bit           m_finishing;
  int           m_pos;
  bit           mon_en = 1'b0;
  int           total  = 0;
  int           bad    = 0;

  function automatic logic [11*N-1:0] model_pack();
    logic [11*N-1:0] p;
    p = '0;
    for (int s = 0; s < 11; s++) p[s*N +: N] = m_slots[s];
    return p;
  endfunction

  // One clock of stimulus; model updated just after the edge
  task automatic cycle(input logic r, input logic s, input logic md, input logic v,
                       input logic [3:0] sl, input logic [N-1:0] dd);
    logic exp_rdy;
    logic acc;
    ev_t  ev;
    int   idx;
    rst = r; start = s; mode = md; in_valid = v; select = sl; data = dd;
    @(negedge clk);
    exp_rdy = !r && !m_finishing && (m_in_frame || !md);
    total++;
    if (in_ready !== exp_rdy) begin
      bad++;
      $display("FAIL in_ready t=%0t got=%b want=%b", $time, in_ready, exp_rdy);
    end
    acc = v && exp_rdy;
    @(posedge clk);
    #1;
    ev = '0;
    if (r) begin
      for (int x = 0; x < 11; x++) m_slots[x] = '0;
      m_in_frame = 0; m_finishing = 0; m_pos = 0;
    end else if (m_finishing) begin
      m_finishing = 0;
    end else if (m_in_frame) begin
      if (s) begin
        m_pos = 0;
`ifdef DEMUX_CLEAR_ON_START_EN
        for (int x = 0; x < 11; x++) m_slots[x] = '0;
`endif
      end
      if (acc) begin
        m_slots[m_pos]   = dd;
        ev.strobe[m_pos] = 1'b1;
        m_pos++;
        if (m_pos == 11) begin
          m_in_frame = 0; m_finishing = 1; m_pos = 0;
          ev.done = 1'b1;
        end
      end
    end else if (md) begin
      if (s) begin
        m_in_frame = 1; m_pos = 0;
`ifdef DEMUX_CLEAR_ON_START_EN
        for (int x = 0; x < 11; x++) m_slots[x] = '0;
`endif
      end
    end else if (acc) begin
      idx = (sl <= 4'd10) ? int'(sl) : 9;
      ev.err = (sl > 4'd10);
      m_slots[idx]   = dd;
      ev.strobe[idx] = 1'b1;
    end
    if (ev != '0) q.push_back(ev);
  endtask

  // Monitor: slot contents every cycle, events popped from the scoreboard
  always @(negedge clk) begin
    ev_t exp;
    if (mon_en) begin
      total++;
      if ({k, j, i, h, g, f, e, d, c, b, a} !== model_pack()) begin
        bad++;
        $display("FAIL slots t=%0t got=%h want=%h", $time,
                 {k, j, i, h, g, f, e, d, c, b, a}, model_pack());
      end
      if (wr_strobe !== 11'd0 || frame_done !== 1'b0 || err_sel !== 1'b0) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event t=%0t strobe=%b done=%b err=%b",
                   $time, wr_strobe, frame_done, err_sel);
        end else begin
          exp = q.pop_front();
          if (wr_strobe !== exp.strobe || frame_done !== exp.done || err_sel !== exp.err) begin
            bad++;
            $display("FAIL event t=%0t got strobe=%b done=%b err=%b want strobe=%b done=%b err=%b",
                     $time, wr_strobe, frame_done, err_sel, exp.strobe, exp.done, exp.err);
          end
        end
      end
    end
  end

  initial begin
    for (int x = 0; x < 11; x++) m_slots[x] = '0;
    m_in_frame = 0; m_finishing = 0; m_pos = 0;

    // Reset held two cycles with in_valid high
    cycle(1, 0, 0, 1, 4'd0, 5'h00);
    cycle(1, 0, 0, 1, 4'd0, 5'h00);
    mon_en = 1'b1;

    // Addressed write to slot d, then out-of-range write landing in j
    cycle(0, 0, 0, 1, 4'd3, 5'h1A);
    cycle(0, 0, 0, 0, 4'd0, 5'h00);
    cycle(0, 0, 0, 1, 4'hE, 5'h07);
    cycle(0, 0, 0, 0, 4'd0, 5'h00);

    // Full sweep with in_valid toggling
    cycle(0, 1, 1, 0, 4'd0, 5'h00);
    for (int w = 1; w <= 11; w++) begin
      cycle(0, 0, 1, 1, 4'd0, N'(w));
      cycle(0, 0, 1, 0, 4'd0, 5'h00);
    end
    cycle(0, 0, 0, 0, 4'd0, 5'h00);

    // Restart after four words, then reset mid-frame
    cycle(0, 1, 1, 0, 4'd0, 5'h00);
    for (int w = 0; w < 4; w++) cycle(0, 0, 1, 1, 4'd0, N'(w + 20));
    cycle(0, 1, 1, 1, 4'd0, 5'h1F);
    cycle(0, 0, 1, 1, 4'd0, 5'h0C);
    cycle(1, 0, 1, 1, 4'd0, 5'h05);
    cycle(0, 0, 0, 0, 4'd0, 5'h00);

    // Preload k, then start a sweep frame
    cycle(0, 0, 0, 1, 4'd10, 5'h11);
    cycle(0, 1, 1, 0, 4'd0, 5'h00);
    cycle(0, 0, 1, 0, 4'd0, 5'h00);
    cycle(1, 0, 0, 0, 4'd0, 5'h00);

    // Randomized traffic
    begin
      logic md;
      md = 1'b0;
      for (int n = 0; n < 1500; n++) begin
        if ($urandom_range(0, 19) == 0) md = ~md;
        cycle(($urandom_range(0, 49) == 0),
              ($urandom_range(0, 6) == 0),
              md,
              ($urandom_range(0, 9) < 7),
              4'($urandom_range(0, 15)),
              N'($urandom));
      end
    end

    // Drain
    for (int n = 0; n < 3; n++) cycle(0, 0, 0, 0, 4'd0, 5'h00);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_demux_1_11_bank
`default_nettype wire

// File: doc/demux_1_11_bank.md
Name: demux_1_11_bank

Overview:
- Inverse of the 11-way select mux in the register/datapath fabric.
- Accepts a stream of N-bit words over a valid/ready handshake and scatters each word into one of 11 registered output slots (a..k).
- Slot choice is either explicit (addressed mode, 4-bit select) or an automatic 0..10 sweep (sweep mode).
- Feeds the decryption datapath's operand slots that the 11:1 mux later reads back.

Parameters:
- N, 5, word width of data and of each slot.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sweep frame (ignored in addressed mode).
- mode  in  1  0 = addressed, 1 = sweep; sampled only in IDLE.
- select  in  4  target slot in addressed mode; encoding 0..10 maps to a..k.
- in_valid  in  1  data word present.
- in_ready  out  1  block can accept a word this cycle.
- data  in  N  word to store.
- a,b,c,d,e,f,g,h,i,j,k  out  N each  registered slot contents.
- wr_strobe  out  11  one-hot; bit s pulses the cycle after slot s is written.
- frame_done  out  1  one-cycle pulse after the 11th sweep write.
- err_sel  out  1  one-cycle pulse after an out-of-range addressed write.

Behaviour:
- Reset, synchronous (rst=1 at a clk edge):
  - all slots = 0; wr_strobe = 0; frame_done = 0; err_sel = 0.
  - state = IDLE; pointer = 0; in_ready = 0 during the reset cycle.
- Reset has priority over every other event. A mid-frame reset abandons the frame: no frame_done, slots zeroed.
- State machine:
  - IDLE, mode=0: addressed operation; in_ready=1.
  - IDLE, mode=1: in_ready=0; start → SWEEP with pointer=0.
  - SWEEP: in_ready=1. Each accept writes the slot at pointer, then pointer+1. The accept at pointer=10 → DONE.
  - DONE: in_ready=0 for exactly one cycle; frame_done=1 in that cycle; then → IDLE.
- Accept means in_valid && in_ready at a clk edge. A write lands in its slot at that edge, so the slot output is valid the next cycle (latency 1).
- Addressed writes:
  - select 0..10: write that slot.
  - select 11..15: write slot j (index 9), matching the mux default, and pulse err_sel.
- wr_strobe: one-hot, registered, aligned with the new slot value. It is all-zero on cycles with no accept.
- start rules:
  - start while in SWEEP restarts the frame (pointer=0). The same-cycle accept, if any, is written to slot a, and the pointer becomes 1.
  - start in DONE or in addressed mode is ignored.
- mode change outside IDLE is ignored until IDLE is re-entered.
- Slots not written hold their value indefinitely.
- No arithmetic beyond the 4-bit pointer, which saturates by state change and never wraps past 10.

Optional Feature:
- Macro DEMUX_CLEAR_ON_START_EN.
- Defined: an accepted start (IDLE→SWEEP or a restart in SWEEP) zeroes all 11 slots in the same edge. Any same-cycle write to slot a still wins.
- Undefined: start never alters slot contents; stale values persist until overwritten.

Decomposition:
- Shared package demux_pkg holds:
  - state enum {IDLE, SWEEP, DONE};
  - constant NUM_SLOTS=11, constant DEFAULT_SLOT=9, constant LAST_SLOT=10;
  - slot index type logic[3:0].
- One natural sub-module: slot_decoder, a combinational 4→11 one-hot decoder with out-of-range→DEFAULT_SLOT mapping and an err flag. It is reused for both the write enables and wr_strobe.

Test Plan:
- Reset check: rst held 2 cycles with in_valid=1 → all slots 0, in_ready=0 during reset, no strobes.
- Addressed write: mode=0, select=3, data=5'h1A, one beat → d=5'h1A next cycle, wr_strobe=11'b000_0000_1000, other slots unchanged.
- Out-of-range write: mode=0, select=4'hE, data=5'h07 → j=5'h07, err_sel pulses once, wr_strobe bit 9 set.
- Full sweep with backpressure:
  - Stimulus: mode=1, start, then words 1..11 with in_valid toggled 1/0.
  - Result: a..k = 1..11; frame_done pulses exactly once, one cycle after the last accept; in_ready=0 in DONE.
- Restart and reset mid-frame:
  - Sweep 4 words, then start with data 5'h1F → a=5'h1F and the pointer continues at slot b.
  - rst during the next beat → all slots 0, no frame_done.
- Macro build: with DEMUX_CLEAR_ON_START_EN, preload k=5'h11, then start → k=0 next cycle. Without the macro, k stays 5'h11.
